// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op encodings and MDU FSM states.
package mips_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_DIVU  = 2'b01;
  localparam logic [1:0] MDU_MTHI  = 2'b10;
  localparam logic [1:0] MDU_MTLO  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  typedef enum logic {MODE_MUL = 1'b0, MODE_DIV = 1'b1} mdu_mode_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of shift-add multiply or restoring shift-subtract divide.
module mdu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_mode_e        mode_i,
  input  logic [WIDTH-1:0] part_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] part_o,
  output logic [WIDTH-1:0] low_o,
  output logic             qbit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    sum     = {1'b0, part_i} + (low_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {part_i, low_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    part_o  = '0;
    low_o   = '0;
    qbit_o  = 1'b0;
    if (mode_i == MODE_MUL) begin
      // {acc, multiplier} shifts right with the adder carry entering the top
      part_o = sum[WIDTH:1];
      low_o  = {sum[0], low_i[WIDTH-1:1]};
    end else begin
      // true remainder always fits in WIDTH bits, so modular subtract is exact
      part_o = shifted[WIDTH-1:0] - (ge ? opnd_i : '0);
      low_o  = {low_i[WIDTH-2:0], 1'b0};
      qbit_o = ge;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers and MTHI/MTLO writes.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  mdu_mode_e        mode;
  logic [WIDTH-1:0] step_part, step_low, next_low;
  logic             step_q;

  assign mode = (state_q == S_DIV) ? MODE_DIV : MODE_MUL;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (mode),
    .part_i (part_q),
    .low_i  (low_q),
    .opnd_i (opnd_q),
    .part_o (step_part),
    .low_o  (step_low),
    .qbit_o (step_q)
  );

  assign next_low = {step_low[WIDTH-1:1], step_low[0] | step_q};
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = (state_q == S_FIN);
  assign div_zero = (state_q == S_FIN) && dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    low_d   = low_q;
    opnd_d  = opnd_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_MUL, S_DIV: begin
        part_d = step_part;
        low_d  = next_low;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // both algorithms leave {remainder|high, quotient|low} in {part, low}
          state_d = S_FIN;
          cnt_d   = '0;
          hi_d    = step_part;
          lo_d    = next_low;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start && !busy) begin
      case (op)
        MDU_MULTU: begin
          state_d = S_MUL;
          cnt_d   = '0;
          part_d  = '0;
          low_d   = rt;
          opnd_d  = rs;
          dz_d    = 1'b0;
        end
        MDU_DIVU: begin
          state_d = S_DIV;
          cnt_d   = '0;
          part_d  = '0;
          low_d   = rs;
          opnd_d  = rt;
          dz_d    = (rt == '0);
        end
        MDU_MTHI: begin
          state_d = S_IDLE;
          hi_d    = rs;
        end
        default: begin
          state_d = S_IDLE;
          lo_d    = rs;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      low_q   <= '0;
      opnd_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      low_q   <= low_d;
      opnd_q  <= opnd_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks of MULTU/DIVU latency, results, MTHI/MTLO, restart and reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Called at a negedge; holds start across exactly one rising edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, counting busy cycles on the way.
  task automatic wait_done(output int bcyc, output bit seen);
    bcyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string nm, input logic [1:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dz);
    int bc; bit seen;
    start_op(o, a, b);
    wait_done(bc, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL %s_timeout: no done pulse", nm); end
    checks++;
    if (bc !== 32) begin failures++; $display("FAIL %s_busy: got %0d cycles want 32", nm, bc); end
    checks++;
    if (hi !== exp_hi) begin failures++; $display("FAIL %s_hi: got %h want %h", nm, hi, exp_hi); end
    checks++;
    if (lo !== exp_lo) begin failures++; $display("FAIL %s_lo: got %h want %h", nm, lo, exp_lo); end
    checks++;
    if (div_zero !== exp_dz) begin failures++; $display("FAIL %s_dz: got %b want %b", nm, div_zero, exp_dz); end
    @(negedge clk);
    checks++;
    if ({done, div_zero, busy} !== 3'b000) begin
      failures++; $display("FAIL %s_after: done/dz/busy=%b want 000", nm, {done, div_zero, busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset: b/d/z=%b hi=%h lo=%h want 000/0/0", {busy, done, div_zero}, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    run_and_check("mul7x6", 2'b00, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
    run_and_check("mulmax", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);
  endtask

  task automatic test_divu();
    run_and_check("div100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_and_check("div80_1", 2'b01, 32'h80000000, 32'd1, 32'h0, 32'h80000000, 1'b0);
    run_and_check("div5_0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
  endtask

  task automatic test_ignore();
    int bc, b2; bit seen;
    bc = 0;
    start_op(2'b00, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    start = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd3;
    if (busy) bc++;
    @(negedge clk);
    start = 1'b0; rs = 32'd55; rt = 32'd66;
    wait_done(b2, seen);
    bc += b2;
    checks++;
    if (!seen || bc !== 32) begin
      failures++; $display("FAIL ignore_timing: seen=%b busy=%0d want 1/32", seen, bc);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'd12) begin
      failures++; $display("FAIL ignore_result: hi=%h lo=%h want 0/c", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit seen;
    start_op(2'b01, 32'd9, 32'd3);
    wait_done(bc, seen);
    checks++;
    if (!seen || lo !== 32'd3 || hi !== 32'd0) begin
      failures++; $display("FAIL b2b_first: seen=%b hi=%h lo=%h want 1/0/3", seen, hi, lo);
    end
    start_op(2'b00, 32'd5, 32'd5);
    wait_done(bc, seen);
    checks++;
    if (!seen || bc !== 32 || lo !== 32'd25 || hi !== 32'd0) begin
      failures++; $display("FAIL b2b_second: seen=%b busy=%0d hi=%h lo=%h want 1/32/0/19", seen, bc, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    lo_before = lo;
    start_op(2'b10, 32'hDEADBEEF, 32'h0);
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== lo_before || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi: hi=%h lo=%h b=%b d=%b want deadbeef/%h/0/0", hi, lo, busy, done, lo_before);
    end
    start_op(2'b11, 32'h1234, 32'h0);
    checks++;
    if (lo !== 32'h1234 || hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mtlo: hi=%h lo=%h b=%b d=%b want deadbeef/1234/0/0", hi, lo, busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hDEADBEEF) begin
      failures++; $display("FAIL mt_hold: hi=%h b=%b d=%b want deadbeef/0/0", hi, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    start_op(2'b01, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_mid: b=%b d=%b hi=%h lo=%h want 0/0/0/0", busy, done, hi, lo);
    end
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd !== 0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_discard: active cycles=%0d lo=%h want 0/0", nd, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_ignore();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
